// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the mem_ctrl CPU memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_ctrl_pkg;

   localparam int MEM_CTRL_ADDR_W  = 8;
   localparam int MEM_CTRL_DATA_W  = 8;
   localparam int MEM_CTRL_LATENCY = 2;

   // Wide enough for the largest WAIT preload (LATENCY 15 -> 13).
   localparam int MEM_CTRL_CNT_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   // WAIT preload. WAIT is never entered through the normal path when
   // latency is 1, so that case returns 0.
   function automatic logic [MEM_CTRL_CNT_W-1:0] wait_cnt_init(input int latency);
      return (latency > 1) ? MEM_CTRL_CNT_W'(latency - 2) : '0;
   endfunction

endpackage

// File: rtl/mem_ctrl_array.sv
// Storage array of 2^ADDR_W x DATA_W, one synchronous write port, two async read ports.
// Latency: writes land at the rising edge; reads are combinational.
// Backpressure: none; every write with we_i high commits.
//
// Ports:
//   clk                 write clock
//   we_i/waddr_i/wdata_i  write port
//   raddr0_i/rdata0_o     read port 0
//   raddr1_i/rdata1_o     read port 1
// Contents are deliberately not reset.
module mem_ctrl_array
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = MEM_CTRL_ADDR_W,
   parameter int DATA_W = MEM_CTRL_DATA_W
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr0_i,
   output logic [DATA_W-1:0] rdata0_o,
   input  logic [ADDR_W-1:0] raddr1_i,
   output logic [DATA_W-1:0] rdata1_o
);

   logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata0_o = mem_q[raddr0_i];
   assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/mem_ctrl.sv
// CPU memory controller: single outstanding read/write with fixed completion latency.
// Latency: request seen in an IDLE cycle -> cpu_ack LATENCY cycles later (one-cycle pulse).
// Backpressure: none queued; requests while cpu_busy is high are dropped, CPU re-requests after ack.
//
// Ports:
//   clk, rst (async, active-low)
//   cpu_rd_req, cpu_wr_req, cpu_addr, cpu_wr_data   request side (write wins if both)
//   cpu_rd_data, cpu_ack, cpu_busy                 registered response side
//   dbg_wen, dbg_addr, dbg_wr_data, dbg_rd_data    debug port, only with MEM_CTRL_DBG_EN
// With MEM_CTRL_DBG_EN defined, a debug write always takes the write port; a CPU write
// commit that collides with it is held off one cycle (ack slips with it).
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W  = MEM_CTRL_ADDR_W,
   parameter int DATA_W  = MEM_CTRL_DATA_W,
   parameter int LATENCY = MEM_CTRL_LATENCY  // legal 1..15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_rd_req,
   input  logic              cpu_wr_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wr_data,
`ifdef MEM_CTRL_DBG_EN
   input  logic              dbg_wen,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wr_data,
   output logic [DATA_W-1:0] dbg_rd_data,
`endif
   output logic [DATA_W-1:0] cpu_rd_data,
   output logic              cpu_ack,
   output logic              cpu_busy
);

   localparam logic [MEM_CTRL_CNT_W-1:0] CNT_INIT = wait_cnt_init(LATENCY);

   state_e                    state_q, state_d;
   logic [MEM_CTRL_CNT_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0]         addr_q, addr_d;
   logic [DATA_W-1:0]         wdata_q, wdata_d;
   logic                      is_wr_q, is_wr_d;
   logic                      ack_q, ack_d;
   logic                      busy_q, busy_d;
   logic [DATA_W-1:0]         rd_data_q, rd_data_d;

   // CPU-side write request towards the array, before arbitration with debug.
   logic                      cpu_we;
   logic [ADDR_W-1:0]         cpu_waddr;
   logic [DATA_W-1:0]         cpu_wdata;

   // Array value at the CPU's current address (live address in IDLE, latched otherwise).
   logic [DATA_W-1:0]         cpu_rd_val;

   // High when a debug write owns the write port this edge.
   logic                      dbg_hit;

   logic                      arr_we;
   logic [ADDR_W-1:0]         arr_waddr;
   logic [DATA_W-1:0]         arr_wdata;
   logic [ADDR_W-1:0]         arr_raddr0, arr_raddr1;
   logic [DATA_W-1:0]         arr_rdata0, arr_rdata1;

`ifdef MEM_CTRL_DBG_EN
   // Port 1 is the debug read port, so the CPU read shares port 0 through a mux.
   assign dbg_hit     = dbg_wen;
   assign arr_we      = dbg_wen | cpu_we;
   assign arr_waddr   = dbg_wen ? dbg_addr    : cpu_waddr;
   assign arr_wdata   = dbg_wen ? dbg_wr_data : cpu_wdata;
   assign arr_raddr0  = (state_q == ST_IDLE) ? cpu_addr : addr_q;
   assign arr_raddr1  = dbg_addr;
   assign cpu_rd_val  = arr_rdata0;
   assign dbg_rd_data = arr_rdata1;
`else
   // CPU is the only writer; port 1 serves the live address for the LATENCY=1 path.
   assign dbg_hit     = 1'b0;
   assign arr_we      = cpu_we;
   assign arr_waddr   = cpu_waddr;
   assign arr_wdata   = cpu_wdata;
   assign arr_raddr0  = addr_q;
   assign arr_raddr1  = cpu_addr;
   assign cpu_rd_val  = (state_q == ST_IDLE) ? arr_rdata1 : arr_rdata0;
`endif

   mem_ctrl_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk      (clk),
      .we_i     (arr_we),
      .waddr_i  (arr_waddr),
      .wdata_i  (arr_wdata),
      .raddr0_i (arr_raddr0),
      .rdata0_o (arr_rdata0),
      .raddr1_i (arr_raddr1),
      .rdata1_o (arr_rdata1)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      is_wr_d   = is_wr_q;
      ack_d     = 1'b0;
      busy_d    = busy_q;
      rd_data_d = rd_data_q;
      cpu_we    = 1'b0;
      cpu_waddr = addr_q;
      cpu_wdata = wdata_q;

      unique case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (cpu_rd_req || cpu_wr_req) begin
               addr_d  = cpu_addr;
               wdata_d = cpu_wr_data;
               is_wr_d = cpu_wr_req;
               busy_d  = 1'b1;
               if (LATENCY > 1) begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
               end else if (cpu_wr_req && dbg_hit) begin
                  // Single-cycle write blocked by debug: park in WAIT with
                  // a zero count so it retries on the next edge.
                  state_d = ST_WAIT;
                  cnt_d   = '0;
               end else begin
                  // LATENCY=1 enters ACK straight away, so commit from the live inputs.
                  state_d = ST_ACK;
                  ack_d   = 1'b1;
                  if (cpu_wr_req) begin
                     cpu_we    = 1'b1;
                     cpu_waddr = cpu_addr;
                     cpu_wdata = cpu_wr_data;
                  end else begin
                     rd_data_d = cpu_rd_val;
                  end
               end
            end
         end

         ST_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - MEM_CTRL_CNT_W'(1);
            end else if (!(is_wr_q && dbg_hit)) begin
               // Reads sample the pre-edge array value, so a debug write
               // on the same edge never delays them.
               state_d = ST_ACK;
               ack_d   = 1'b1;
               if (is_wr_q) begin
                  cpu_we = 1'b1;
               end else begin
                  rd_data_d = cpu_rd_val;
               end
            end
         end

         ST_ACK: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         is_wr_q   <= 1'b0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         is_wr_q   <= is_wr_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign cpu_ack     = ack_q;
   assign cpu_busy    = busy_q;
   assign cpu_rd_data = rd_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: random CPU traffic against a reference array model with a scoreboard.
// Latency: expected ack cycle = cycle the request was presented + LAT (+1 per debug collision).
// Backpressure: the driver waits for each ack before issuing the next request.
module tb_mem_ctrl;

   localparam int AW = 8;
   localparam int DW = 8;
   parameter  int LAT = 2;
`ifdef MEM_CTRL_DBG_EN
   localparam bit DBG = 1'b1;
`else
   localparam bit DBG = 1'b0;
`endif

   typedef struct {
      bit            is_rd;
      logic [DW-1:0] data;
      int            ack_cyc;
      int            busy_len;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          cpu_rd_req, cpu_wr_req;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wr_data;
   logic [DW-1:0] cpu_rd_data;
   logic          cpu_ack, cpu_busy;
`ifdef MEM_CTRL_DBG_EN
   logic          dbg_wen;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wr_data;
   logic [DW-1:0] dbg_rd_data;
`endif

   mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
`ifdef MEM_CTRL_DBG_EN
      .dbg_wen     (dbg_wen),
      .dbg_addr    (dbg_addr),
      .dbg_wr_data (dbg_wr_data),
      .dbg_rd_data (dbg_rd_data),
`endif
      .clk         (clk),
      .rst         (rst),
      .cpu_rd_req  (cpu_rd_req),
      .cpu_wr_req  (cpu_wr_req),
      .cpu_addr    (cpu_addr),
      .cpu_wr_data (cpu_wr_data),
      .cpu_rd_data (cpu_rd_data),
      .cpu_ack     (cpu_ack),
      .cpu_busy    (cpu_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int            errors = 0;
   int            checks = 0;
   int            done_cnt = 0;
   int            busy_run = 0;
   int            last_ack_cyc = 0;
   exp_t          sb[$];
   logic [DW-1:0] mem_m [0:(1<<AW)-1];
   logic [DW-1:0] last_rd = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every ack pops one expectation and checks timing, busy duration and read data.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         busy_run = 0;
      end else begin
         if (cpu_busy) busy_run++;
         if (cpu_ack) begin
            done_cnt++;
            last_ack_cyc = cyc;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: got ack with empty scoreboard (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               check("ack_cycle", cyc, e.ack_cyc);
               check("busy_cycles", busy_run, e.busy_len);
               check(e.is_rd ? "rd_data" : "rd_data_hold", cpu_rd_data, e.data);
            end
            busy_run = 0;
         end
      end
   end

   // Called at #1 after a rising edge with the DUT idle; returns at the same phase
   // right after the ack cycle, so back-to-back calls issue in the cycle after ACK.
   task automatic cpu_op(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit junk, input bit collide);
      exp_t e;
      int   issue;
      int   start;
      bit   coll;
      coll        = collide && wr;
      cpu_rd_req  = rd;
      cpu_wr_req  = wr;
      cpu_addr    = a;
      cpu_wr_data = d;
      issue       = cyc;
      start       = done_cnt;
      e.ack_cyc   = issue + LAT + (coll ? 1 : 0);
      e.busy_len  = LAT + (coll ? 1 : 0);
      if (wr) begin
         mem_m[a] = d;
         e.is_rd  = 1'b0;
         e.data   = last_rd;
      end else begin
         e.is_rd  = 1'b1;
         e.data   = mem_m[a];
         last_rd  = mem_m[a];
      end
      sb.push_back(e);
`ifdef MEM_CTRL_DBG_EN
      if (coll && LAT == 1) begin
         dbg_wen = 1'b1; dbg_addr = a; dbg_wr_data = ~d;
      end
`endif
      for (int k = 0; k < LAT + 10; k++) begin
         tick();
         if (cyc == issue + 1) begin
            cpu_rd_req = 1'b0;
            cpu_wr_req = 1'b0;
            if (junk) begin
               // Must be ignored: the controller is busy on this edge.
               cpu_rd_req  = 1'b1;
               cpu_wr_req  = 1'($urandom % 2);
               cpu_addr    = ~a;
               cpu_wr_data = ~d;
            end
         end
         if (cyc == issue + 2) begin
            cpu_rd_req = 1'b0;
            cpu_wr_req = 1'b0;
         end
`ifdef MEM_CTRL_DBG_EN
         if (coll && LAT > 1 && cyc == issue + LAT - 1) begin
            dbg_wen = 1'b1; dbg_addr = a; dbg_wr_data = ~d;
         end
         if (coll && cyc == issue + LAT) dbg_wen = 1'b0;
`endif
         if (done_cnt != start) return;
      end
      cpu_rd_req = 1'b0;
      cpu_wr_req = 1'b0;
      check("ack_timeout", done_cnt - start, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int first_ack;
      rst         = 1'b0;
      cpu_rd_req  = 1'b0;
      cpu_wr_req  = 1'b0;
      cpu_addr    = '0;
      cpu_wr_data = '0;
`ifdef MEM_CTRL_DBG_EN
      dbg_wen     = 1'b0;
      dbg_addr    = '0;
      dbg_wr_data = '0;
`endif
      #3;
      check("reset_ack", cpu_ack, 0);
      check("reset_busy", cpu_busy, 0);
      check("reset_rd_data", cpu_rd_data, 0);
      repeat (2) tick();
      rst = 1'b1;

      // Basic write then read back.
      cpu_op(1'b0, 1'b1, 8'd10, 8'd5, 1'b0, 1'b0);
      cpu_op(1'b1, 1'b0, 8'd10, 8'd0, 1'b0, 1'b0);

      // Read and write together: write wins, read data register untouched.
      cpu_op(1'b1, 1'b1, 8'd4, 8'd7, 1'b0, 1'b0);
      cpu_op(1'b1, 1'b0, 8'd4, 8'd0, 1'b0, 1'b0);

      // Reset in the middle of a write aborts it; array keeps the older value.
      cpu_op(1'b0, 1'b1, 8'd3, 8'h21, 1'b0, 1'b0);
      cpu_wr_req  = 1'b1;
      cpu_addr    = 8'd3;
      cpu_wr_data = 8'd9;
      if (LAT > 1) tick();
      rst        = 1'b0;
      cpu_wr_req = 1'b0;
      #1;
      check("abort_busy", cpu_busy, 0);
      check("abort_ack", cpu_ack, 0);
      check("abort_rd_data", cpu_rd_data, 0);
      repeat (3) tick();
      rst     = 1'b1;
      last_rd = '0;
      cpu_op(1'b1, 1'b0, 8'd3, 8'd0, 1'b0, 1'b0);

`ifdef MEM_CTRL_DBG_EN
      // Debug preload 0..7 with i+3, then back-to-back CPU reads.
      for (int i = 0; i < 8; i++) begin
         dbg_wen     = 1'b1;
         dbg_addr    = AW'(i);
         dbg_wr_data = DW'(i + 3);
         mem_m[i]    = DW'(i + 3);
         tick();
      end
      dbg_wen = 1'b0;
      for (int i = 0; i < 8; i += 3) begin
         dbg_addr = AW'(i);
         #1;
         check("dbg_rd_data", dbg_rd_data, mem_m[i]);
      end
      tick();
      cpu_op(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
      first_ack = last_ack_cyc;
      for (int i = 1; i < 8; i++) cpu_op(1'b1, 1'b0, AW'(i), 8'd0, 1'b0, 1'b0);
      check("b2b_ack_spacing", last_ack_cyc - first_ack, 7 * (LAT + 1));

      // Debug write on the CPU commit edge: CPU slips a cycle and lands last.
      cpu_op(1'b0, 1'b1, 8'd12, 8'h55, 1'b0, 1'b1);
      cpu_op(1'b1, 1'b0, 8'd12, 8'd0, 1'b0, 1'b0);
`endif

      // Random traffic over a pre-initialised window of addresses.
      for (int a = 16; a < 32; a++) cpu_op(1'b0, 1'b1, AW'(a), DW'($urandom), 1'b0, 1'b0);
      for (int n = 0; n < 60; n++) begin
         int kind;
         kind = $urandom_range(0, 2);
         repeat ($urandom_range(0, 2)) tick();
         cpu_op(kind != 1, kind != 0, AW'(16 + $urandom_range(0, 15)), DW'($urandom),
                1'($urandom % 2), DBG && ($urandom % 3 == 0));
      end

      repeat (4) tick();
      check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
